// File: rtl/eeprom_pkg.sv
// Shared types and constants for the EEPROM host sequencer.
// One-hot state encoding, timer defaults and pattern helpers.
package eeprom_pkg;

    localparam int TWR_CYCLES_DEF  = 1000;
    localparam int ACK_TIMEOUT_DEF = 1023;
    localparam int TMR_W           = 16;

    typedef enum logic [5:0] {
        ST_IDLE   = 6'b000001,
        ST_WR_REQ = 6'b000010,
        ST_WR_GAP = 6'b000100,
        ST_RD_REQ = 6'b001000,
        ST_CHECK  = 6'b010000,
        ST_FIN    = 6'b100000
    } state_e;

    function automatic logic [7:0] pattern_byte(
        input logic [7:0] seed,
        input logic [7:0] idx
    );
        return seed + idx;
    endfunction

    function automatic logic [10:0] seq_addr(
        input logic [10:0] base,
        input logic [7:0]  idx
    );
        return base + {3'b000, idx};
    endfunction

endpackage

// File: rtl/eeprom_host_seq_if.sv
// Request/ack bus between the sequencer and an I2C EEPROM master.
// The slave side returns read data through rdata when rdrv is high.
interface eeprom_host_seq_if;

    logic        wr;
    logic        rd;
    logic [10:0] addr;
    logic        ack;
    logic [7:0]  rdata;
    logic        rdrv;

    modport master (
        output wr,
        output rd,
        output addr,
        input  ack
    );

    modport slave (
        input  wr,
        input  rd,
        input  addr,
        output ack,
        output rdata,
        output rdrv
    );

endinterface

// File: rtl/eeprom_cyc_timer.sv
// Loadable down-counter shared by the write gap and ACK timeout.
// Holds at zero; zero_o reflects the registered count.
module eeprom_cyc_timer
    import eeprom_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [TMR_W-1:0] val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [TMR_W-1:0] cnt_q;
    logic [TMR_W-1:0] cnt_d;

    // Next count: load wins over decrement, saturate at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = val_i;
        end else if (dec_i && cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/eeprom_host_seq.sv
// EEPROM write-then-verify sequencer driving an I2C EEPROM master.
// Writes a seeded byte pattern, waits out tWR, reads back and compares.
module eeprom_host_seq
    import eeprom_pkg::*;
#(
    parameter int TWR_CYCLES  = TWR_CYCLES_DEF,
    parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        START,
    input  logic [10:0] BASE_ADDR,
    input  logic [7:0]  COUNT,
    input  logic [7:0]  SEED,
    output logic        WR,
    output logic        RD,
    output logic [10:0] ADDR,
    inout  wire  [7:0]  DATA,
    input  logic        ACK,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERR,
    output logic [7:0]  ERR_CNT,
    output logic [10:0] FAIL_ADDR
);

    // Timer counts N-1 down to 0, so a phase lasts exactly N cycles.
    localparam logic [TMR_W-1:0] TWR_LOAD = TMR_W'(TWR_CYCLES - 1);
    localparam logic [TMR_W-1:0] ACK_LOAD = TMR_W'(ACK_TIMEOUT - 1);

    state_e      state_q;
    logic [10:0] base_q;
    logic [7:0]  count_q;
    logic [7:0]  seed_q;
    logic [7:0]  idx_q;
    logic        wr_q;
    logic        rd_q;
    logic [10:0] addr_q;
    logic        busy_q;
    logic        done_q;
    logic        err_q;
    logic [7:0]  err_cnt_q;
    logic [10:0] fail_q;
    logic [7:0]  rdata_q;

    logic             tmr_load;
    logic [TMR_W-1:0] tmr_val;
    logic             tmr_dec;
    logic             tmr_zero;

    logic       last;
    logic [7:0] idx_nx;
    logic [7:0] pat;

    assign last   = (idx_q == count_q - 8'd1);
    assign idx_nx = idx_q + 8'd1;
    assign pat    = pattern_byte(seed_q, idx_q);

    eeprom_cyc_timer u_timer (
        .clk_i  (CLK),
        .rst_i  (RESET),
        .load_i (tmr_load),
        .val_i  (tmr_val),
        .dec_i  (tmr_dec),
        .zero_o (tmr_zero)
    );

    // Timer control: arm on entry to each timed phase, count down inside it.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = ACK_LOAD;
        tmr_dec  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                tmr_load = START && (COUNT != 8'd0);
            end
            ST_WR_REQ: begin
                if (ACK) begin
                    tmr_load = 1'b1;
                    tmr_val  = TWR_LOAD;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ST_WR_GAP: begin
                if (tmr_zero) begin
                    tmr_load = 1'b1;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ST_RD_REQ: begin
                tmr_dec = !ACK;
            end
            ST_CHECK: begin
                tmr_load = !last;
            end
            default: begin
            end
        endcase
    end

    // Sequencer FSM with registered bus and status outputs.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= ST_IDLE;
            base_q    <= '0;
            count_q   <= '0;
            seed_q    <= '0;
            idx_q     <= '0;
            wr_q      <= 1'b0;
            rd_q      <= 1'b0;
            addr_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
            fail_q    <= '0;
            rdata_q   <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (START) begin
                        base_q    <= BASE_ADDR;
                        count_q   <= COUNT;
                        seed_q    <= SEED;
                        idx_q     <= '0;
                        busy_q    <= 1'b1;
                        err_q     <= 1'b0;
                        err_cnt_q <= '0;
                        fail_q    <= '0;
                        if (COUNT != 8'd0) begin
                            wr_q    <= 1'b1;
                            addr_q  <= BASE_ADDR;
                            state_q <= ST_WR_REQ;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= ST_FIN;
                        end
                    end
                end
                ST_WR_REQ: begin
                    if (ACK) begin
                        wr_q    <= 1'b0;
                        state_q <= ST_WR_GAP;
                    end else if (tmr_zero) begin
                        wr_q   <= 1'b0;
                        err_q  <= 1'b1;
                        done_q <= 1'b1;
                        if (!err_q) begin
                            fail_q <= addr_q;
                        end
                        state_q <= ST_FIN;
                    end
                end
                ST_WR_GAP: begin
                    if (tmr_zero) begin
                        if (last) begin
                            idx_q   <= '0;
                            rd_q    <= 1'b1;
                            addr_q  <= base_q;
                            state_q <= ST_RD_REQ;
                        end else begin
                            idx_q   <= idx_nx;
                            wr_q    <= 1'b1;
                            addr_q  <= seq_addr(base_q, idx_nx);
                            state_q <= ST_WR_REQ;
                        end
                    end
                end
                ST_RD_REQ: begin
                    if (ACK) begin
                        rd_q    <= 1'b0;
                        rdata_q <= DATA;
                        state_q <= ST_CHECK;
                    end else if (tmr_zero) begin
                        rd_q   <= 1'b0;
                        err_q  <= 1'b1;
                        done_q <= 1'b1;
                        if (!err_q) begin
                            fail_q <= addr_q;
                        end
                        state_q <= ST_FIN;
                    end
                end
                ST_CHECK: begin
                    if (rdata_q != pat) begin
                        err_q <= 1'b1;
                        if (err_cnt_q != 8'hFF) begin
                            err_cnt_q <= err_cnt_q + 8'd1;
                        end
                        if (!err_q) begin
                            fail_q <= addr_q;
                        end
                    end
                    if (last) begin
                        done_q  <= 1'b1;
                        state_q <= ST_FIN;
                    end else begin
                        idx_q   <= idx_nx;
                        rd_q    <= 1'b1;
                        addr_q  <= seq_addr(base_q, idx_nx);
                        state_q <= ST_RD_REQ;
                    end
                end
                ST_FIN: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign WR        = wr_q;
    assign RD        = rd_q;
    assign ADDR      = addr_q;
    assign DATA      = (state_q == ST_WR_REQ) ? pat : 8'hzz;
    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign ERR       = err_q;
    assign ERR_CNT   = err_cnt_q;
    assign FAIL_ADDR = fail_q;

endmodule

// File: tb/tb_eeprom_host_seq.sv
// Directed bench for eeprom_host_seq with an EEPROM responder model.
// Responder acks on negedge; the bench samples #1 after posedge.
module tb_eeprom_host_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [10:0] base;
    logic [7:0]  cnt;
    logic [7:0]  seed;
    logic        busy;
    logic        done;
    logic        err;
    logic [7:0]  err_cnt;
    logic [10:0] fail_addr;
    wire  [7:0]  data_w;

    int nvec = 0;
    int nerr = 0;

    eeprom_host_seq_if bus ();

    assign data_w = bus.rdrv ? bus.rdata : 8'hzz;

    eeprom_host_seq dut (
        .CLK       (clk),
        .RESET     (rst),
        .START     (start),
        .BASE_ADDR (base),
        .COUNT     (cnt),
        .SEED      (seed),
        .WR        (bus.wr),
        .RD        (bus.rd),
        .ADDR      (bus.addr),
        .DATA      (data_w),
        .ACK       (bus.ack),
        .BUSY      (busy),
        .DONE      (done),
        .ERR       (err),
        .ERR_CNT   (err_cnt),
        .FAIL_ADDR (fail_addr)
    );

    always #5 clk = ~clk;

    // Responder model configuration (written only by the stimulus).
    bit          hold_ack = 1'b0;
    bit          bad_en   = 1'b0;
    logic [10:0] bad_addr = '0;

    logic [7:0]  mem [0:2047];
    int          lat = 0;
    logic [10:0] wa [$];
    logic [7:0]  wd [$];
    logic [10:0] ra [$];

    // EEPROM model: ack each request on its third cycle, echo memory.
    always @(negedge clk) begin
        bus.ack  = 1'b0;
        bus.rdrv = 1'b0;
        if (bus.wr || bus.rd) begin
            if (lat == 2) begin
                lat = 0;
                if (bus.wr && !hold_ack) begin
                    mem[bus.addr] = data_w;
                    wa.push_back(bus.addr);
                    wd.push_back(data_w);
                    bus.ack = 1'b1;
                end else if (bus.rd) begin
                    if (bad_en && bus.addr == bad_addr) begin
                        bus.rdata = 8'hFF;
                    end else begin
                        bus.rdata = mem[bus.addr];
                    end
                    ra.push_back(bus.addr);
                    bus.rdrv = 1'b1;
                    bus.ack  = 1'b1;
                end
            end else begin
                lat++;
            end
        end else begin
            lat = 0;
        end
    end

    // Bus monitor: overlap, request edges, WR run lengths, write gaps.
    int overlap  = 0;
    int wr_rise  = 0;
    int rd_rise  = 0;
    int wr_run   = 0;
    int idle_run = 0;
    bit wr_prev  = 1'b0;
    bit rd_prev  = 1'b0;
    bit had_wr   = 1'b0;
    int wruns [$];
    int gaps [$];

    always @(negedge clk) begin
        if (bus.wr && bus.rd) overlap++;
        if (bus.wr && !wr_prev) begin
            wr_rise++;
            if (had_wr) gaps.push_back(idle_run);
        end
        if (bus.rd && !rd_prev) rd_rise++;
        if (bus.wr) begin
            wr_run++;
        end else if (wr_prev) begin
            wruns.push_back(wr_run);
            wr_run = 0;
        end
        if (bus.wr || bus.rd) idle_run = 0;
        else idle_run++;
        if (bus.wr) had_wr = 1'b1;
        else if (bus.rd || !busy) had_wr = 1'b0;
        wr_prev = bus.wr;
        rd_prev = bus.rd;
    end

    task automatic do_run(
        input  logic [10:0] b,
        input  logic [7:0]  c,
        input  logic [7:0]  s,
        output bit          got_done,
        output int          wait_cyc,
        output logic        done_nx,
        output logic        busy_nx
    );
        @(posedge clk); #1;
        base  = b;
        cnt   = c;
        seed  = s;
        start = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        got_done = 1'b0;
        wait_cyc = 0;
        while (!got_done && wait_cyc < 20000) begin
            if (done) begin
                got_done = 1'b1;
            end else begin
                @(posedge clk); #1;
                wait_cyc++;
            end
        end
        @(posedge clk); #1;
        done_nx = done;
        busy_nx = busy;
    endtask

    task automatic test_reset(input string tag);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL %s_busy got=%0b exp=0", tag, busy); end
        nvec++; if (done !== 1'b0) begin nerr++; $display("FAIL %s_done got=%0b exp=0", tag, done); end
        nvec++; if (err !== 1'b0) begin nerr++; $display("FAIL %s_err got=%0b exp=0", tag, err); end
        nvec++; if (err_cnt !== 8'd0) begin nerr++; $display("FAIL %s_errcnt got=%0d exp=0", tag, err_cnt); end
        nvec++; if (fail_addr !== 11'd0) begin nerr++; $display("FAIL %s_failaddr got=%h exp=000", tag, fail_addr); end
        nvec++; if (bus.wr !== 1'b0) begin nerr++; $display("FAIL %s_wr got=%0b exp=0", tag, bus.wr); end
        nvec++; if (bus.rd !== 1'b0) begin nerr++; $display("FAIL %s_rd got=%0b exp=0", tag, bus.rd); end
        nvec++; if (bus.addr !== 11'd0) begin nerr++; $display("FAIL %s_addr got=%h exp=000", tag, bus.addr); end
    endtask

    task automatic test_basic();
        int w0 = wa.size();
        int r0 = ra.size();
        int g0 = gaps.size();
        int ov0 = overlap;
        bit gd;
        int wc;
        logic dn, bn;
        logic [10:0] ea;
        logic [7:0] ed;
        do_run(11'h010, 8'd4, 8'hA0, gd, wc, dn, bn);
        nvec++; if (gd !== 1'b1) begin nerr++; $display("FAIL basic_done got=%0b exp=1", gd); end
        nvec++; if (dn !== 1'b0) begin nerr++; $display("FAIL basic_done_width got=%0b exp=0", dn); end
        nvec++; if (bn !== 1'b0) begin nerr++; $display("FAIL basic_busy_after got=%0b exp=0", bn); end
        nvec++; if (wa.size() - w0 !== 4) begin nerr++; $display("FAIL basic_nwr got=%0d exp=4", wa.size() - w0); end
        nvec++; if (ra.size() - r0 !== 4) begin nerr++; $display("FAIL basic_nrd got=%0d exp=4", ra.size() - r0); end
        for (int i = 0; i < 4; i++) begin
            ea = 11'h010 + 11'(i);
            ed = 8'hA0 + 8'(i);
            nvec++; if (wa[w0 + i] !== ea) begin nerr++; $display("FAIL basic_waddr[%0d] got=%h exp=%h", i, wa[w0 + i], ea); end
            nvec++; if (wd[w0 + i] !== ed) begin nerr++; $display("FAIL basic_wdata[%0d] got=%h exp=%h", i, wd[w0 + i], ed); end
            nvec++; if (ra[r0 + i] !== ea) begin nerr++; $display("FAIL basic_raddr[%0d] got=%h exp=%h", i, ra[r0 + i], ea); end
        end
        nvec++; if (err !== 1'b0) begin nerr++; $display("FAIL basic_err got=%0b exp=0", err); end
        nvec++; if (err_cnt !== 8'd0) begin nerr++; $display("FAIL basic_errcnt got=%0d exp=0", err_cnt); end
        nvec++; if (overlap - ov0 !== 0) begin nerr++; $display("FAIL basic_overlap got=%0d exp=0", overlap - ov0); end
        nvec++; if (gaps.size() - g0 !== 3) begin nerr++; $display("FAIL basic_ngaps got=%0d exp=3", gaps.size() - g0); end
        nvec++; if (gaps[g0] !== 1000) begin nerr++; $display("FAIL basic_twr_gap got=%0d exp=1000", gaps[g0]); end
    endtask

    task automatic test_wrap();
        int w0 = wa.size();
        int r0 = ra.size();
        bit gd;
        int wc;
        logic dn, bn;
        logic [10:0] exp_a [3];
        exp_a[0] = 11'h7FE;
        exp_a[1] = 11'h7FF;
        exp_a[2] = 11'h000;
        do_run(11'h7FE, 8'd3, 8'h00, gd, wc, dn, bn);
        nvec++; if (gd !== 1'b1) begin nerr++; $display("FAIL wrap_done got=%0b exp=1", gd); end
        for (int i = 0; i < 3; i++) begin
            nvec++; if (wa[w0 + i] !== exp_a[i]) begin nerr++; $display("FAIL wrap_waddr[%0d] got=%h exp=%h", i, wa[w0 + i], exp_a[i]); end
            nvec++; if (wd[w0 + i] !== 8'(i)) begin nerr++; $display("FAIL wrap_wdata[%0d] got=%h exp=%h", i, wd[w0 + i], 8'(i)); end
            nvec++; if (ra[r0 + i] !== exp_a[i]) begin nerr++; $display("FAIL wrap_raddr[%0d] got=%h exp=%h", i, ra[r0 + i], exp_a[i]); end
        end
        nvec++; if (err !== 1'b0) begin nerr++; $display("FAIL wrap_err got=%0b exp=0", err); end
    endtask

    task automatic test_corrupt();
        int r0 = ra.size();
        bit gd;
        int wc;
        logic dn, bn;
        bad_en   = 1'b1;
        bad_addr = 11'h011;
        do_run(11'h010, 8'd4, 8'hA0, gd, wc, dn, bn);
        bad_en = 1'b0;
        nvec++; if (gd !== 1'b1) begin nerr++; $display("FAIL corrupt_done got=%0b exp=1", gd); end
        nvec++; if (err !== 1'b1) begin nerr++; $display("FAIL corrupt_err got=%0b exp=1", err); end
        nvec++; if (err_cnt !== 8'd1) begin nerr++; $display("FAIL corrupt_errcnt got=%0d exp=1", err_cnt); end
        nvec++; if (fail_addr !== 11'h011) begin nerr++; $display("FAIL corrupt_failaddr got=%h exp=011", fail_addr); end
        nvec++; if (ra.size() - r0 !== 4) begin nerr++; $display("FAIL corrupt_nrd got=%0d exp=4", ra.size() - r0); end
    endtask

    task automatic test_timeout();
        int w0 = wa.size();
        int n0 = wruns.size();
        int rr0 = rd_rise;
        bit gd;
        int wc;
        logic dn, bn;
        hold_ack = 1'b1;
        do_run(11'h010, 8'd4, 8'h20, gd, wc, dn, bn);
        hold_ack = 1'b0;
        nvec++; if (gd !== 1'b1) begin nerr++; $display("FAIL timeout_done got=%0b exp=1", gd); end
        nvec++; if (err !== 1'b1) begin nerr++; $display("FAIL timeout_err got=%0b exp=1", err); end
        nvec++; if (fail_addr !== 11'h010) begin nerr++; $display("FAIL timeout_failaddr got=%h exp=010", fail_addr); end
        nvec++; if (err_cnt !== 8'd0) begin nerr++; $display("FAIL timeout_errcnt got=%0d exp=0", err_cnt); end
        nvec++; if (rd_rise - rr0 !== 0) begin nerr++; $display("FAIL timeout_rd_issued got=%0d exp=0", rd_rise - rr0); end
        nvec++; if (wa.size() - w0 !== 0) begin nerr++; $display("FAIL timeout_nwr got=%0d exp=0", wa.size() - w0); end
        nvec++; if (wruns.size() - n0 !== 1) begin nerr++; $display("FAIL timeout_nwrruns got=%0d exp=1", wruns.size() - n0); end
        nvec++; if (wruns[n0] !== 1023) begin nerr++; $display("FAIL timeout_wr_len got=%0d exp=1023", wruns[n0]); end
    endtask

    task automatic test_zero_and_busy();
        int wr0 = wr_rise;
        int rr0 = rd_rise;
        int w0;
        int r0;
        int k;
        bit gd;
        int wc;
        logic dn, bn;
        do_run(11'h123, 8'd0, 8'h11, gd, wc, dn, bn);
        nvec++; if (gd !== 1'b1) begin nerr++; $display("FAIL zero_done got=%0b exp=1", gd); end
        nvec++; if (wc !== 0) begin nerr++; $display("FAIL zero_done_delay got=%0d exp=0", wc); end
        nvec++; if (dn !== 1'b0) begin nerr++; $display("FAIL zero_done_width got=%0b exp=0", dn); end
        nvec++; if (bn !== 1'b0) begin nerr++; $display("FAIL zero_busy_after got=%0b exp=0", bn); end
        nvec++; if (wr_rise - wr0 !== 0) begin nerr++; $display("FAIL zero_wr got=%0d exp=0", wr_rise - wr0); end
        nvec++; if (rd_rise - rr0 !== 0) begin nerr++; $display("FAIL zero_rd got=%0d exp=0", rd_rise - rr0); end
        w0 = wa.size();
        r0 = ra.size();
        @(posedge clk); #1;
        base  = 11'h100;
        cnt   = 8'd1;
        seed  = 8'h55;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        base  = 11'h200;
        cnt   = 8'd3;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        k = 0;
        while (!done && k < 5000) begin
            @(posedge clk); #1;
            k++;
        end
        nvec++; if (done !== 1'b1) begin nerr++; $display("FAIL busy_ign_done got=%0b exp=1", done); end
        nvec++; if (wa.size() - w0 !== 1) begin nerr++; $display("FAIL busy_ign_nwr got=%0d exp=1", wa.size() - w0); end
        nvec++; if (wa[w0] !== 11'h100) begin nerr++; $display("FAIL busy_ign_waddr got=%h exp=100", wa[w0]); end
        nvec++; if (ra.size() - r0 !== 1) begin nerr++; $display("FAIL busy_ign_nrd got=%0d exp=1", ra.size() - r0); end
        nvec++; if (err !== 1'b0) begin nerr++; $display("FAIL busy_ign_err got=%0b exp=0", err); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int w0 = wa.size();
        int wr0 = wr_rise;
        int k = 0;
        @(posedge clk); #1;
        base  = 11'h020;
        cnt   = 8'd4;
        seed  = 8'h10;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (wa.size() - w0 < 2 && k < 5000) begin
            @(posedge clk); #1;
            k++;
        end
        nvec++; if (wa.size() - w0 !== 2) begin nerr++; $display("FAIL rstmid_reach_gap got=%0d exp=2", wa.size() - w0); end
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL rstmid_busy got=%0b exp=0", busy); end
        nvec++; if (done !== 1'b0) begin nerr++; $display("FAIL rstmid_done got=%0b exp=0", done); end
        nvec++; if (bus.wr !== 1'b0) begin nerr++; $display("FAIL rstmid_wr got=%0b exp=0", bus.wr); end
        nvec++; if (bus.rd !== 1'b0) begin nerr++; $display("FAIL rstmid_rd got=%0b exp=0", bus.rd); end
        nvec++; if (bus.addr !== 11'd0) begin nerr++; $display("FAIL rstmid_addr got=%h exp=000", bus.addr); end
        nvec++; if (err !== 1'b0) begin nerr++; $display("FAIL rstmid_err got=%0b exp=0", err); end
        repeat (1200) @(posedge clk);
        #1;
        nvec++; if (wr_rise - wr0 !== 2) begin nerr++; $display("FAIL rstmid_no_resume got=%0d exp=2", wr_rise - wr0); end
        nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL rstmid_idle_busy got=%0b exp=0", busy); end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        base  = '0;
        cnt   = '0;
        seed  = '0;
        repeat (3) @(posedge clk);
        test_reset("reset");
        test_basic();
        test_wrap();
        test_corrupt();
        test_reset("reset_after_err");
        test_timeout();
        test_zero_and_busy();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "simulation time limit");
    end

endmodule
